// File: rtl/gate_check_seq.sv
// gate_check_seq: exhaustive 2-input sweep of an external gate expected to be XOR.
// Each of the four operand vectors is driven for HOLD cycles. The gate response is
// then sampled for one cycle. Mismatches are counted, saturating at 255, over
// PASSES full sweeps.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start             - run request (ignored while busy)
//   a, b              - operands driven into the gate; {a,b} == vec
//   c                 - gate response
//   vec               - current vector index
//   busy              - high while driving or sampling
//   done              - high once the run has completed
//   pass              - done with zero mismatches
//   err_count         - mismatch count of the current/last run
module gate_check_seq #(
    parameter int unsigned HOLD   = 2,
    parameter int unsigned PASSES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       c,
    output logic [1:0] vec,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count
);

    localparam int unsigned HOLD_W = 4;
    localparam int unsigned PASS_W = 8;
    localparam int unsigned ERR_W  = 8;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t            state, state_n;
    logic [1:0]        vec_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic [PASS_W-1:0] pass_cnt, pass_cnt_n;
    logic [ERR_W-1:0]  err_n;
    logic              busy_n, done_n, pass_n;

    // Next-state and next-output logic
    always_comb begin
        state_n    = state;
        vec_n      = vec;
        hold_n     = hold_cnt;
        pass_cnt_n = pass_cnt;
        err_n      = err_count;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n    = S_DRIVE;
                    vec_n      = 2'd0;
                    hold_n     = '0;
                    pass_cnt_n = '0;
                    err_n      = '0;
                end
            end
            S_DRIVE: begin
                hold_n = HOLD_W'(hold_cnt + 4'd1);
                if (hold_cnt == HOLD_LAST) begin
                    state_n = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                // Reference behaviour is XOR of the operands currently driven
                if (((vec[1] ^ vec[0]) != c) && (err_count != ERR_MAX)) begin
                    err_n = ERR_W'(err_count + 8'd1);
                end
                if ((vec == 2'd3) && (pass_cnt == PASS_LAST)) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_DRIVE;
                    vec_n   = 2'(vec + 2'd1);
                    hold_n  = '0;
                    if (vec == 2'd3) begin
                        pass_cnt_n = PASS_W'(pass_cnt + 8'd1);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        busy_n = (state_n == S_DRIVE) || (state_n == S_SAMPLE);
        done_n = (state_n == S_DONE);
        pass_n = done_n && (err_n == '0);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            vec       <= 2'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            hold_cnt  <= '0;
            pass_cnt  <= '0;
            err_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            state     <= state_n;
            vec       <= vec_n;
            a         <= vec_n[1];
            b         <= vec_n[0];
            hold_cnt  <= hold_n;
            pass_cnt  <= pass_cnt_n;
            err_count <= err_n;
            busy      <= busy_n;
            done      <= done_n;
            pass      <= pass_n;
        end
    end

endmodule

// File: doc/gate_check_seq.md
GATE_CHECK_SEQ -- requirements
Module: gate_check_seq

Interface
REQ-001 The block SHALL have parameter HOLD, default 2, giving cycles each input vector is driven before its response is sampled (legal range 1..15).
REQ-002 The block SHALL have parameter PASSES, default 4, giving full 4-vector sweeps per run (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, with asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit, a run request sampled on clk.
REQ-006 The block SHALL have port a, output, 1 bit, the first operand driven into the gate under test.
REQ-007 The block SHALL have port b, output, 1 bit, the second operand driven into the gate under test.
REQ-008 The block SHALL have port c, input, 1 bit, the response of the gate under test.
REQ-009 The block SHALL have port vec, output, 2 bits, the current vector index; {a,b} SHALL equal vec at all times.
REQ-010 The block SHALL have port busy, output, 1 bit, which is high while in DRIVE or SAMPLE.
REQ-011 The block SHALL have port done, output, 1 bit, which is high while in DONE.
REQ-012 The block SHALL have port pass, output, 1 bit, equal to done AND (err_count==0).
REQ-013 The block SHALL have port err_count, output, 8 bits, the mismatch count for the current or last run.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, DRIVE, SAMPLE and DONE; a, b, vec, busy, done and err_count SHALL be registered outputs.
REQ-015 In IDLE, when start=1, the next state SHALL be DRIVE, and vec, hold counter, pass counter and err_count SHALL all clear to 0; when start=0, the FSM SHALL stay in IDLE.
REQ-016 In DRIVE, the hold counter SHALL increment each cycle, and the FSM SHALL move to SAMPLE on the cycle where the hold counter equals HOLD-1; with HOLD=1 it SHALL spend exactly one cycle in DRIVE.
REQ-017 SAMPLE SHALL last exactly one cycle: on that edge, c SHALL be compared with a XOR b, and on a mismatch err_count SHALL increment, saturating at 255 (no wrap).
REQ-018 On leaving SAMPLE, if vec==3 and pass counter==PASSES-1, the next state SHALL be DONE with vec held at 3.
REQ-019 On leaving SAMPLE otherwise, vec SHALL increment modulo 4 (3->0 increments the pass counter), the hold counter SHALL clear, and the next state SHALL be DRIVE.
REQ-020 Each vector SHALL occupy HOLD+1 cycles, and busy SHALL stay high for exactly 4*PASSES*(HOLD+1) consecutive cycles (48 at defaults).
REQ-021 start SHALL be ignored while busy=1.
REQ-022 In DONE, err_count and pass SHALL hold; start=1 SHALL restart exactly as from IDLE (err_count cleared); start=0 SHALL keep the FSM in DONE.
REQ-023 Once a run starts, done SHALL go high on the cycle after the last SAMPLE, with busy and done never both high.

Reset
REQ-024 While rst_n=0, regardless of clk, the state SHALL be IDLE and a, b, vec, busy, done, pass, err_count and all internal counters SHALL be 0.
REQ-025 When rst_n is asserted mid-run, the run SHALL be abandoned immediately with no partial result retained, and after release the FSM SHALL wait in IDLE for start.

Verification
REQ-026 With ideal XOR on c, defaults, and a 1-cycle start pulse: busy SHALL be high for 48 cycles, {a,b} SHALL step 00,01,10,11 each 3 cycles, and then done=1, pass=1, err_count=0.
REQ-027 With c tied to 0, defaults: at done, err_count SHALL be 8 (vectors 01 and 10 times 4 passes) and pass=0.
REQ-028 With c = NOT(a XOR b), PASSES=100: err_count SHALL saturate at 255 with no wrap, and pass=0.
REQ-029 With rst_n pulsed low mid-run (cycle 20): all outputs SHALL go to 0 asynchronously, and the FSM SHALL remain IDLE after release until start.
REQ-030 With start held high throughout a run, the run SHALL be unaffected; start in DONE after a failing run SHALL clear err_count to 0 and begin a new 48-cycle run.
REQ-031 With HOLD=1, PASSES=1 and ideal XOR: busy SHALL be high for 8 cycles, then done=1 and pass=1.
